// File: rtl/bcd_code_conv_seq_pkg.sv
// Shared constants for the sequential BCD code converter: target-code selectors
// and the controller state encoding.
package bcd_code_conv_seq_pkg;

  localparam logic [1:0] MODE_2421 = 2'b00;
  localparam logic [1:0] MODE_XS3  = 2'b01;
  localparam logic [1:0] MODE_5421 = 2'b10;
  localparam logic [1:0] MODE_8421 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CONV = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bcd_code_conv_seq_if.sv
// Valid/ready word interface between a BCD source, the converter and its consumer.
interface bcd_code_conv_seq_if #(parameter int W = 16);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_bcd;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic         out_err;

  modport master (
    output in_valid, in_bcd, in_mode, out_ready,
    input  in_ready, out_valid, out_code, out_err
  );

  modport slave (
    input  in_valid, in_bcd, in_mode, out_ready,
    output in_ready, out_valid, out_code, out_err
  );

endinterface

// File: rtl/bcd_code_conv_seq_digit_conv.sv
// Combinational single-digit converter from 8421 BCD to the selected target code;
// digits above 9 map to 0000 and raise invalid.
module bcd_digit_conv
  import bcd_code_conv_seq_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [1:0] mode,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = 4'd0;
    invalid = 1'b0;
    if (digit > 4'd9) begin
      invalid = 1'b1;
    end else begin
      case (mode)
        MODE_2421: code = (digit < 4'd5) ? digit : digit + 4'd6;
        MODE_XS3:  code = digit + 4'd3;
        MODE_5421: code = (digit < 4'd5) ? digit : digit + 4'd3;
        default:   code = digit;
      endcase
    end
  end

endmodule

// File: rtl/bcd_code_conv_seq.sv
// Sequential BCD code converter: accepts a word, converts one digit per cycle
// through a shared digit converter, then holds the result until taken.
module bcd_code_conv_seq
  import bcd_code_conv_seq_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 4 * DIGITS
) (
  input  logic clk,
  input  logic rst_n,
  bcd_code_conv_seq_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [W-1:0]  word;
  logic [1:0]    mode;
  logic [W-1:0]  code;
  logic          err;
  logic [31:0]   base;
  logic [3:0]    dig, dig_code;
  logic          dig_inv;

  assign base = 32'(idx) << 2;
  assign dig  = word[base +: 4];

  bcd_digit_conv u_conv (
    .digit   (dig),
    .mode    (mode),
    .code    (dig_code),
    .invalid (dig_inv)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.in_valid)  state_nx = S_CONV;
      S_CONV:  if (idx == LAST)   state_nx = S_DONE;
      S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      word  <= '0;
      mode  <= MODE_2421;
      code  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (bus.in_valid) begin
          word <= bus.in_bcd;
          mode <= bus.in_mode;
          idx  <= '0;
          code <= '0;
          err  <= 1'b0;
        end
        S_CONV: begin
          code[base +: 4] <= dig_code;
          err             <= err | dig_inv;
          idx             <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_code  = code;
  assign bus.out_err   = err;

endmodule

// File: tb/tb_bcd_code_conv_seq.sv
// Directed and randomized checks of bcd_code_conv_seq (DIGITS=4) against a
// table-driven digit model.
module tb_bcd_code_conv_seq;
  import bcd_code_conv_seq_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  bcd_code_conv_seq_if #(.W(W)) bus ();

  bcd_code_conv_seq #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: code tables written straight from the digit mappings.
  function automatic void model(input logic [W-1:0] w, input logic [1:0] m,
                                output logic [W-1:0] code, output logic err);
    int t2421 [10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
    int t5421 [10] = '{0, 1, 2, 3, 4, 8, 9, 10, 11, 12};
    int d, r;
    code = '0;
    err  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(w[4*i +: 4]);
      if (d > 9) begin
        r = 0;
        err = 1'b1;
      end else if (m == MODE_2421) r = t2421[d];
      else if (m == MODE_XS3)      r = d + 3;
      else if (m == MODE_5421)     r = t5421[d];
      else                         r = d;
      code[4*i +: 4] = 4'(r);
    end
  endfunction

  task automatic run_word(input string tag, input logic [W-1:0] w, input logic [1:0] m,
                          input int hold);
    logic [W-1:0] ec;
    logic         ee;
    int           k;
    model(w, m, ec, ee);
    bus.in_bcd   = w;
    bus.in_mode  = m;
    bus.in_valid = 1'b1;
    chk({tag, ".ready"}, 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    // Garbage on the input side while the word is in flight must be ignored.
    bus.in_bcd  = W'($urandom);
    bus.in_mode = 2'($urandom);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      chk({tag, ".busy"}, 32'(bus.in_ready), 0);
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".lat"}, 32'(k), DIGITS);
    chk({tag, ".code"}, 32'(bus.out_code), 32'(ec));
    chk({tag, ".err"}, 32'(bus.out_err), 32'(ee));
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, ".hold_v"}, 32'(bus.out_valid), 1);
      chk({tag, ".hold_r"}, 32'(bus.in_ready), 0);
      chk({tag, ".hold_c"}, 32'(bus.out_code), 32'(ec));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".rel_v"}, 32'(bus.out_valid), 0);
    chk({tag, ".rel_r"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    logic [W-1:0] w;
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.in_mode   = MODE_2421;
    bus.out_ready = 1'b0;
    #12;
    chk("rst.ready", 32'(bus.in_ready), 1);
    chk("rst.valid", 32'(bus.out_valid), 0);
    chk("rst.code", 32'(bus.out_code), 0);
    chk("rst.err", 32'(bus.out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_word("aiken", 16'h5937, MODE_2421, 0);
    chk("aiken.lit", 32'(bus.out_code), 32'h0000BF3D);
    run_word("xs3", 16'h1290, MODE_XS3, 1);
    run_word("b5421", 16'h0789, MODE_5421, 0);
    run_word("badA", 16'h12A4, MODE_2421, 0);
    run_word("stall", 16'h4682, MODE_8421, 3);

    // Reset in the second conversion cycle drops the word at once.
    bus.in_bcd = 16'h9999; bus.in_mode = MODE_XS3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst.code", 32'(bus.out_code), 0);
    chk("arst.err", 32'(bus.out_err), 0);
    chk("arst.valid", 32'(bus.out_valid), 0);
    chk("arst.ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_word("post", 16'h0000, MODE_8421, 0);
    chk("post.lit", 32'(bus.out_code), 0);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < DIGITS; i++)
        w[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      run_word("rnd", w, 2'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
